// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one producer at a time a bounded
// burst into a shared FIFO write port, stalling (not revoking) on fifo_full.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_wr_data,
  output logic                       grant_active,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]      state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  idx;
  logic [IDW-1:0]  next_ptr;
  logic [BCW-1:0]  burst_cnt;
  logic [DATA_W-1:0] sel_data;
  logic            any_valid;
  logic            in_grant;
  logic            xfer;
  logic            last_beat;
  logic            release_g;

  // First valid requester searching upward from rr_ptr with wrap-around.
  always_comb begin
    any_valid = 1'b0;
    pick      = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((32'(rr_ptr) + k) % NUM_REQ);
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        pick      = idx;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == grant_id) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Reset gates the outputs combinationally so they drop in the reset cycle itself.
  assign in_grant     = (state == GRANT) && !reset;
  assign xfer         = in_grant && req_valid[grant_id] && !fifo_full;
  assign last_beat    = (burst_cnt == BCW'(MAX_BURST - 1));
  assign release_g    = in_grant && (!req_valid[grant_id] || (xfer && last_beat));
  assign next_ptr     = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  assign grant_active = in_grant;
  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = in_grant ? sel_data : '0;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = in_grant && !fifo_full && (IDW'(i) == grant_id);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id  <= pick;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) burst_cnt <= burst_cnt + 1'b1;
          if (release_g) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: burst length, round-robin order, full stall,
// early release and mid-burst reset, plus a running write-port scoreboard.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   valid2;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready, rdy2;
  logic            fifo_full;
  logic            fifo_wr_en, we2;
  logic [DW-1:0]   fifo_wr_data, wd2;
  logic            grant_active, ga2;
  logic [1:0]      grant_id, gid2;

  // Producer i presents {i, 0x100 + words already accepted}.
  logic [11:0] cnt      [NR] = '{default: 12'h000};
  logic [11:0] next_seq [NR] = '{default: 12'h100};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .grant_active(grant_active), .grant_id(grant_id));

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(valid2), .req_data(req_data),
    .req_ready(rdy2), .fifo_full(1'b0), .fifo_wr_en(we2),
    .fifo_wr_data(wd2), .grant_active(ga2), .grant_id(gid2));

  always_comb begin
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {4'(i), 12'h100 + cnt[i]};
  end

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++)
      if (!reset && req_valid[i] && req_ready[i]) cnt[i] <= cnt[i] + 12'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      if (fifo_wr_en) begin
        chk("write_while_full", 32'(fifo_full), 32'd0);
        chk("data_order", 32'(fifo_wr_data[11:0]), 32'(next_seq[fifo_wr_data[15:12]]));
        next_seq[fifo_wr_data[15:12]] = fifo_wr_data[11:0] + 12'd1;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".active"}, 32'(grant_active), 32'd0);
    chk({tag, ".wr_en"},  32'(fifo_wr_en),   32'd0);
    chk({tag, ".ready"},  32'(req_ready),    32'd0);
    chk({tag, ".data"},   32'(fifo_wr_data), 32'd0);
  endtask

  task automatic expect_grant(input string tag, input int gid, input logic we,
                              input logic [DW-1:0] wd, input logic [NR-1:0] rdy);
    chk({tag, ".active"}, 32'(grant_active), 32'd1);
    chk({tag, ".id"},     32'(grant_id),     32'(gid));
    chk({tag, ".wr_en"},  32'(fifo_wr_en),   32'(we));
    chk({tag, ".data"},   32'(fifo_wr_data), 32'(wd));
    chk({tag, ".ready"},  32'(req_ready),    32'(rdy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = '0; valid2 = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b0100;
    smp(); expect_idle("reset_hold");

    // Single producer 2, burst of 8 then bubble then re-grant.
    nxt(); reset = 1'b0;
    smp(); expect_idle("c0");
    for (int k = 0; k < 8; k++) begin
      nxt(); smp(); expect_grant("t1_burst", 2, 1'b1, 16'h2100 + 16'(k), 4'b0100);
    end
    nxt(); smp(); expect_idle("t1_bubble");
    nxt(); smp(); expect_grant("t1_regrant", 2, 1'b1, 16'h2108, 4'b0100);
    nxt(); req_valid = '0;
    smp(); expect_grant("t1_drop", 2, 1'b0, 16'h2109, 4'b0100);
    nxt(); smp(); expect_idle("t1_idle");

    // Producer 1 stalled by fifo_full for 4 cycles mid-burst.
    nxt(); req_valid = 4'b0010;
    smp(); expect_idle("s_arb");
    nxt(); smp(); expect_grant("s_w0", 1, 1'b1, 16'h1100, 4'b0010);
    nxt(); smp(); expect_grant("s_w1", 1, 1'b1, 16'h1101, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      nxt(); fifo_full = 1'b1;
      smp(); expect_grant("s_stall", 1, 1'b0, 16'h1102, 4'b0000);
    end
    for (int k = 0; k < 6; k++) begin
      nxt(); fifo_full = 1'b0;
      smp(); expect_grant("s_resume", 1, 1'b1, 16'h1102 + 16'(k), 4'b0010);
    end
    nxt(); req_valid = '0;
    smp(); expect_idle("s_release");

    // Producer 0 drops valid after 3 words; 3 waits and wins next (rr_ptr=1).
    nxt(); req_valid = 4'b0001;
    smp(); expect_idle("e_arb");
    nxt(); smp(); expect_grant("e_w0", 0, 1'b1, 16'h0100, 4'b0001);
    nxt(); req_valid = 4'b1001;
    smp(); expect_grant("e_w1", 0, 1'b1, 16'h0101, 4'b0001);
    nxt(); smp(); expect_grant("e_w2", 0, 1'b1, 16'h0102, 4'b0001);
    nxt(); req_valid = 4'b1000;
    smp(); expect_grant("e_drop", 0, 1'b0, 16'h0103, 4'b0001);
    nxt(); smp(); expect_idle("e_bubble");
    nxt(); smp(); expect_grant("e_next3", 3, 1'b1, 16'h3100, 4'b1000);
    nxt(); req_valid = '0;
    smp(); expect_grant("e_drop3", 3, 1'b0, 16'h3101, 4'b1000);
    nxt(); smp(); expect_idle("e_idle");

    // Reset for one cycle after the 4th transfer of producer 2.
    nxt(); req_valid = 4'b0100;
    smp(); expect_idle("r_arb");
    for (int k = 0; k < 4; k++) begin
      nxt(); smp(); expect_grant("r_burst", 2, 1'b1, 16'h2109 + 16'(k), 4'b0100);
    end
    nxt(); reset = 1'b1; req_valid = 4'b0110;
    smp(); expect_idle("r_during");
    nxt(); reset = 1'b0;
    smp(); expect_idle("r_after");
    nxt(); smp(); expect_grant("r_lowest", 1, 1'b1, 16'h1108, 4'b0010);
    nxt(); req_valid = '0;
    smp(); expect_grant("r_drop", 1, 1'b0, 16'h1109, 4'b0010);
    nxt(); smp(); expect_idle("r_idle");

    // MAX_BURST=2 instance, all four requesting: 0,1,2,3,0 with 1-cycle bubbles.
    nxt(); valid2 = 4'b1111;
    smp(); chk("rr_arb.active", 32'(ga2), 32'd0);
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 2; b++) begin
        nxt(); smp();
        chk("rr_beat.active", 32'(ga2),  32'd1);
        chk("rr_beat.id",     32'(gid2), 32'(g % 4));
        chk("rr_beat.wr_en",  32'(we2),  32'd1);
      end
      nxt(); smp();
      chk("rr_bubble.active", 32'(ga2), 32'd0);
      chk("rr_bubble.wr_en",  32'(we2), 32'd0);
    end
    valid2 = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `my_fifo` instance among NUM_REQ producers. Each producer presents data on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `wr_en`/`wr_data`, honouring `full`. It sits directly in front of the FIFO write port; the FIFO read side is untouched.

## Interface
Parameters:
- NUM_REQ, 4, number of producers (2..16)
- DATA_W, 128, data width; equals FIFO DATA_W
- MAX_BURST, 8, maximum transfers per grant (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-producer data valid
- req_data  in  NUM_REQ*DATA_W  packed producer data; producer i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-producer accept; one-hot or zero
- fifo_full  in  1  FIFO `full`
- fifo_wr_en  out  1  FIFO write enable
- fifo_wr_data  out  DATA_W  FIFO write data
- grant_active  out  1  a grant is held (state GRANT)
- grant_id  out  $clog2(NUM_REQ)  index of granted producer

## Operation
- FSM states: IDLE, GRANT. All state is registered.
- Reset values: state IDLE, grant_id 0, rr_ptr 0, burst_cnt 0.
- While reset is high, fifo_wr_en=0, req_ready=0, grant_active=0 and fifo_wr_data=0, regardless of state.
- IDLE behaviour:
  - If any req_valid is set, select the first set bit searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
  - Register it into grant_id, clear burst_cnt, and go to GRANT.
  - If no req_valid is set, stay in IDLE.
- GRANT combinational outputs:
  - xfer = req_valid[grant_id] & ~fifo_full.
  - req_ready[grant_id] = ~fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = xfer.
  - fifo_wr_data = req_data slice for grant_id.
- On each xfer, burst_cnt increments. burst_cnt width is $clog2(MAX_BURST+1); it never exceeds MAX_BURST.
- GRANT -> IDLE, with rr_ptr <= grant_id+1 (mod NUM_REQ), occurs on either of:
  - (a) xfer while burst_cnt == MAX_BURST-1, i.e. the MAX_BURST-th transfer;
  - (b) req_valid[grant_id]=0, whether or not fifo_full is set.
- fifo_full=1 with req_valid held: stay in GRANT with no transfer and no count change. The grant is not revoked, so a stalled producer keeps the FIFO.
- Data is never dropped or duplicated. A write happens only when fifo_wr_en=1, and the FIFO never sees wr_en=1 while full=1.
- Outside GRANT, fifo_wr_data is 0.
- rr_ptr changes only on release, which guarantees each valid producer is granted within NUM_REQ-1 other grants.

## Timing
- Arbitration latency: req_valid rising in IDLE in cycle N gives grant_active=1 and the first possible transfer in cycle N+1.
- Release bubble: after the releasing edge the block spends one cycle in IDLE arbitrating. The next burst's first transfer is 2 cycles after the last transfer of the previous burst. Peak throughput is MAX_BURST/(MAX_BURST+1).
- fifo_full to fifo_wr_en is a combinational path, the same cycle. The FIFO's full is itself registered-count based, so no loop exists.
- Reset asserted mid-burst: outputs go to 0 in that same cycle. In the cycle after reset deasserts the state is IDLE with rr_ptr 0, and the partially completed burst is not resumed.
- MAX_BURST=1: every transfer releases the grant.

## Test plan
- Single producer, NUM_REQ=4, MAX_BURST=8; req_valid[2] held high from cycle 0 with data 0x100+k, fifo_full=0:
  - grant_id=2 from cycle 1; writes of 0x100..0x107 in cycles 1-8;
  - IDLE in cycle 9; re-grant to 2 in cycle 10;
  - FIFO contents are in order with no gaps.
- All four producers continuously valid, MAX_BURST=2: grant order 0,1,2,3,0,..., each grant exactly 2 writes, with a 1-cycle bubble between grants.
- Full stall: producer 1 granted, fifo_full=1 for cycles 3-6:
  - fifo_wr_en=0 and req_ready=0 in cycles 3-6;
  - burst_cnt frozen, grant held;
  - transfers resume in cycle 7 with the same data word the producer was holding.
- Early drop: producer 0 sends 3 words then deasserts valid while producers 0 and 3 are requesting:
  - release after word 3;
  - next grant goes to 3 (rr_ptr=1, search 1,2,3), not 0.
- Reset mid-burst: reset high for 1 cycle after the 4th transfer of producer 2:
  - fifo_wr_en=0 in the reset cycle;
  - grant_active=0 in the next cycle;
  - next grant is the lowest valid index from 0.
- Scoreboard across all tests: every write occurs with fifo_full=0; req_ready is never multi-hot; per-producer data order is preserved.
